// File: rtl/mem_ctrl_arb_if.sv
// Bus bundle for mem_ctrl_arb: the IF and MEM request channels, the shared
// read-data/status outputs and the byte-wide RAM port.
//   slave  : controller side (takes requests and ram_din, drives done/rdata/RAM strobes)
//   master : requester/RAM side (drives requests and ram_din, observes the rest)
// Signals:
//   if_req/if_addr/if_flush/if_done                  IF read channel
//   mem_req/mem_we/mem_size/mem_addr_i/mem_wdata/
//   mem_done                                         MEM read/write channel
//   rdata_o, busy                                    shared result and status
//   ram_addr/ram_wr/ram_dout/ram_din                 byte-serial RAM port
interface mem_ctrl_arb_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_flush;
    logic              if_done;

    logic              mem_req;
    logic              mem_we;
    logic [1:0]        mem_size;
    logic [ADDR_W-1:0] mem_addr_i;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_done;

    logic [DATA_W-1:0] rdata_o;
    logic              busy;

    logic [ADDR_W-1:0] ram_addr;
    logic              ram_wr;
    logic [7:0]        ram_dout;
    logic [7:0]        ram_din;

    modport slave (
        input  if_req, if_addr, if_flush,
        input  mem_req, mem_we, mem_size, mem_addr_i, mem_wdata,
        input  ram_din,
        output if_done, mem_done, rdata_o, busy,
        output ram_addr, ram_wr, ram_dout
    );

    modport master (
        output if_req, if_addr, if_flush,
        output mem_req, mem_we, mem_size, mem_addr_i, mem_wdata,
        output ram_din,
        input  if_done, mem_done, rdata_o, busy,
        input  ram_addr, ram_wr, ram_dout
    );
endinterface

// File: rtl/mem_ctrl_arb.sv
// Byte-serial memory controller arbitrating an IF (read-only) channel and a
// MEM (read/write) channel onto one 8-bit RAM port. Requests of 1, 2 or 4
// bytes are moved one byte per beat; reads are assembled little-endian into
// rdata_o, writes are split from the latched write word.
// Ports:
//   clk   : clock, all state on the rising edge
//   rst   : asynchronous active-low reset
//   bus   : mem_ctrl_arb_if slave modport (channels, status, RAM port)
// Parameters:
//   ADDR_W   byte-address width
//   DATA_W   channel word width (multiple of 8)
//   RD_LAT   wait cycles between a RAM address change and the ram_din sample
//   ARB_MODE 0 = MEM always wins a tie, 1 = round-robin
module mem_ctrl_arb #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int RD_LAT   = 1,
    parameter int ARB_MODE = 0
) (
    input  logic          clk,
    input  logic          rst,
    mem_ctrl_arb_if.slave bus
);
    localparam int BYTES  = DATA_W / 8;
    localparam int BEAT_W = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam int WAIT_W = $clog2(RD_LAT + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state, state_nxt;
    logic              own_mem, own_mem_nxt;     // 1 = MEM owns the transfer
    logic              last_mem, last_mem_nxt;   // round-robin pointer: MEM granted last
    logic              we_q, we_nxt;
    logic [BEAT_W-1:0] beat, beat_nxt;
    logic [BEAT_W-1:0] last_beat, last_beat_nxt;
    logic [WAIT_W-1:0] wcnt, wcnt_nxt;
    logic [ADDR_W-1:0] addr_q, addr_nxt;
    logic              ram_wr_q, ram_wr_nxt;
    logic [7:0]        dout_q, dout_nxt;
    logic [DATA_W-1:0] rdata_q, rdata_nxt;
    logic [DATA_W-1:0] wdata_q, wdata_nxt;
    logic              if_done_q, if_done_nxt;
    logic              mem_done_q, mem_done_nxt;
    logic              grant_mem;
    logic              beat_last;
    logic [BEAT_W-1:0] beat_inc;

    // Index of the final beat for a size code, clipped to the channel width.
    function automatic logic [BEAT_W-1:0] last_beat_of(input logic [1:0] size);
        int n;
        case (size)
            2'b00:   n = 1;
            2'b01:   n = 2;
            default: n = 4;
        endcase
        if (n > BYTES) n = BYTES;
        return BEAT_W'(n - 1);
    endfunction

    assign beat_last = (beat == last_beat);
    assign beat_inc  = beat + 1'b1;

    // Tie-break only matters when both channels request in the same cycle.
    always_comb begin
        grant_mem = bus.mem_req;
        if (bus.mem_req && bus.if_req) begin
            grant_mem = (ARB_MODE == 0) ? 1'b1 : !last_mem;
        end
    end

    always_comb begin
        state_nxt     = state;
        own_mem_nxt   = own_mem;
        last_mem_nxt  = last_mem;
        we_nxt        = we_q;
        beat_nxt      = beat;
        last_beat_nxt = last_beat;
        wcnt_nxt      = wcnt;
        addr_nxt      = addr_q;
        ram_wr_nxt    = ram_wr_q;
        dout_nxt      = dout_q;
        rdata_nxt     = rdata_q;
        wdata_nxt     = wdata_q;
        if_done_nxt   = 1'b0;
        mem_done_nxt  = 1'b0;

        unique case (state)
            IDLE: begin
                if (bus.if_req || bus.mem_req) begin
                    own_mem_nxt   = grant_mem;
                    last_mem_nxt  = grant_mem;
                    we_nxt        = grant_mem && bus.mem_we;
                    addr_nxt      = grant_mem ? bus.mem_addr_i : bus.if_addr;
                    last_beat_nxt = grant_mem ? last_beat_of(bus.mem_size) : last_beat_of(2'b10);
                    wdata_nxt     = bus.mem_wdata;
                    beat_nxt      = '0;
                    wcnt_nxt      = '0;
                    rdata_nxt     = '0;
                    ram_wr_nxt    = grant_mem && bus.mem_we;
                    dout_nxt      = (grant_mem && bus.mem_we) ? bus.mem_wdata[7:0] : 8'h00;
                    state_nxt     = BUSY;
                end
            end

            BUSY: begin
                if (!own_mem && bus.if_flush) begin
                    // Aborted IF read: drop straight back, keep partial rdata.
                    addr_nxt  = '0;
                    state_nxt = IDLE;
                end else if (we_q) begin
                    // The byte on ram_dout is committed at this edge.
                    if (beat_last) begin
                        ram_wr_nxt   = 1'b0;
                        addr_nxt     = '0;
                        mem_done_nxt = own_mem;
                        if_done_nxt  = !own_mem;
                        state_nxt    = DONE;
                    end else begin
                        addr_nxt = addr_q + 1'b1;
                        beat_nxt = beat_inc;
                        dout_nxt = wdata_q[{beat_inc, 3'b000} +: 8];
                    end
                end else begin
                    if (wcnt != WAIT_W'(RD_LAT)) begin
                        wcnt_nxt = wcnt + 1'b1;
                    end else begin
                        rdata_nxt[{beat, 3'b000} +: 8] = bus.ram_din;
                        if (beat_last) begin
                            addr_nxt     = '0;
                            mem_done_nxt = own_mem;
                            if_done_nxt  = !own_mem;
                            state_nxt    = DONE;
                        end else begin
                            addr_nxt = addr_q + 1'b1;
                            beat_nxt = beat_inc;
                            wcnt_nxt = '0;
                        end
                    end
                end
            end

            DONE: begin
                // done pulses for this one cycle; grants resume from IDLE.
                state_nxt = IDLE;
            end

            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            own_mem    <= 1'b0;
            last_mem   <= 1'b0;
            we_q       <= 1'b0;
            beat       <= '0;
            last_beat  <= '0;
            wcnt       <= '0;
            addr_q     <= '0;
            ram_wr_q   <= 1'b0;
            dout_q     <= 8'h00;
            rdata_q    <= '0;
            if_done_q  <= 1'b0;
            mem_done_q <= 1'b0;
        end else begin
            state      <= state_nxt;
            own_mem    <= own_mem_nxt;
            last_mem   <= last_mem_nxt;
            we_q       <= we_nxt;
            beat       <= beat_nxt;
            last_beat  <= last_beat_nxt;
            wcnt       <= wcnt_nxt;
            addr_q     <= addr_nxt;
            ram_wr_q   <= ram_wr_nxt;
            dout_q     <= dout_nxt;
            rdata_q    <= rdata_nxt;
            if_done_q  <= if_done_nxt;
            mem_done_q <= mem_done_nxt;
        end
    end

    // Latched write word is pure data and never read before it is loaded.
    always_ff @(posedge clk) begin
        wdata_q <= wdata_nxt;
    end

    assign bus.ram_addr = addr_q;
    assign bus.ram_wr   = ram_wr_q;
    assign bus.ram_dout = dout_q;
    assign bus.rdata_o  = rdata_q;
    assign bus.if_done  = if_done_q;
    assign bus.mem_done = mem_done_q;
    assign bus.busy     = (state != IDLE);
endmodule

// File: tb/tb_mem_ctrl_arb.sv
// Self-checking bench for mem_ctrl_arb: a fixed-priority instance with a
// modelled 1 KiB byte RAM, and a round-robin instance for the tie-break order.
module tb_mem_ctrl_arb;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int RD_LAT = 1;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mem_ctrl_arb_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) b0 ();
    mem_ctrl_arb_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) b1 ();

    mem_ctrl_arb #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT), .ARB_MODE(0))
        dut0 (.clk(clk), .rst(rst), .bus(b0));
    mem_ctrl_arb #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT), .ARB_MODE(1))
        dut1 (.clk(clk), .rst(rst), .bus(b1));

    // Bench RAM behind dut0, indexed by the low 10 address bits.
    logic [7:0] ram [1024];
    logic [7:0] model_mem [1024];
    logic       ram_clr = 1'b0;
    logic       poke_en = 1'b0;
    logic [9:0] poke_addr = '0;
    logic [7:0] poke_data = '0;

    assign b0.ram_din = ram[b0.ram_addr[9:0]];
    assign b1.ram_din = b1.ram_addr[7:0] ^ 8'h3C;

    always @(posedge clk) begin
        if (ram_clr) begin
            for (int i = 0; i < 1024; i++) ram[i] <= 8'h00;
        end else if (poke_en) begin
            ram[poke_addr] <= poke_data;
        end else if (b0.ram_wr) begin
            ram[b0.ram_addr[9:0]] <= b0.ram_dout;
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic poke(input logic [9:0] a, input logic [7:0] d);
        poke_addr = a;
        poke_data = d;
        poke_en   = 1'b1;
        step();
        poke_en   = 1'b0;
        model_mem[a] = d;
    endtask

    // Reference model: transfer size, cycle cost and byte-level memory image.
    function automatic int nbytes(input bit mem, input logic [1:0] size);
        if (!mem) return 4;
        case (size)
            2'b00:   return 1;
            2'b01:   return 2;
            default: return 4;
        endcase
    endfunction

    function automatic int model_lat(input bit mem, input bit we, input logic [1:0] size);
        return 1 + nbytes(mem, size) * ((mem && we) ? 1 : RD_LAT + 1);
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] addr, input int n);
        logic [31:0] r;
        logic [31:0] a;
        r = '0;
        for (int i = 0; i < n; i++) begin
            a = addr + 32'(i);
            r[8*i +: 8] = model_mem[a[9:0]];
        end
        return r;
    endfunction

    task automatic model_write(input logic [31:0] addr, input logic [31:0] wdata, input int n);
        logic [31:0] a;
        for (int i = 0; i < n; i++) begin
            a = addr + 32'(i);
            model_mem[a[9:0]] = wdata[8*i +: 8];
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ram_addr"}, b0.ram_addr, 0);
        check({tag, "_rdata"}, b0.rdata_o, 0);
        check({tag, "_ctrl"}, {b0.ram_wr, b0.ram_dout, b0.if_done, b0.mem_done, b0.busy}, 0);
    endtask

    // One transaction on dut0; requester drops req once done is seen.
    task automatic run_txn(input bit mem, input bit we, input logic [1:0] size,
                           input logic [31:0] addr, input logic [31:0] wdata, input bit flush,
                           output logic [31:0] rdata, output int lat);
        int stray;
        bit seen;
        stray = 0;
        seen  = 1'b0;
        lat   = 0;
        rdata = '0;
        b0.if_addr    = addr;
        b0.mem_addr_i = addr;
        b0.mem_we     = we;
        b0.mem_size   = size;
        b0.mem_wdata  = wdata;
        b0.if_flush   = flush;
        if (mem) b0.mem_req = 1'b1;
        else     b0.if_req  = 1'b1;
        for (int c = 1; c <= 60 && !seen; c++) begin
            step();
            if (c == 1) check("busy_after_grant", b0.busy, 1);
            if (mem ? b0.mem_done : b0.if_done) begin
                seen  = 1'b1;
                lat   = c;
                rdata = b0.rdata_o;
            end
            if (mem ? b0.if_done : b0.mem_done) stray++;
        end
        b0.if_req   = 1'b0;
        b0.mem_req  = 1'b0;
        b0.if_flush = 1'b0;
        step();
        check("done_one_cycle", mem ? b0.mem_done : b0.if_done, 0);
        check("stray_done", stray, 0);
    endtask

    typedef struct {
        bit          mem;
        bit          we;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        bit          flush;
        logic [31:0] exp_rdata;
        int          exp_lat;
    } vec_t;

    vec_t vecs [15];

    initial begin
        logic [31:0] rd;
        logic [31:0] exp_rd;
        int          lat;
        int          mem_at;
        int          if_at;
        int          ifd;
        int          mism;
        int          order [$];
        bit          mem_rearm;
        bit          if_rearm;
        bit          r_mem, r_we, r_flush;
        logic [1:0]  r_size;
        logic [31:0] r_addr, r_wdata;

        b0.if_req = 0; b0.if_addr = '0; b0.if_flush = 0;
        b0.mem_req = 0; b0.mem_we = 0; b0.mem_size = '0; b0.mem_addr_i = '0; b0.mem_wdata = '0;
        b1.if_req = 0; b1.if_addr = '0; b1.if_flush = 0;
        b1.mem_req = 0; b1.mem_we = 0; b1.mem_size = '0; b1.mem_addr_i = '0; b1.mem_wdata = '0;
        for (int i = 0; i < 1024; i++) model_mem[i] = 8'h00;

        //            mem we  size   addr          wdata         fl   rdata         lat
        vecs[0]  = '{1'b0, 1'b0, 2'b10, 32'h0000_0100, 32'h0,        1'b0, 32'h44332211, 9};
        vecs[1]  = '{1'b1, 1'b1, 2'b01, 32'h0000_0020, 32'hAABBCCDD, 1'b0, 32'h0,        3};
        vecs[2]  = '{1'b1, 1'b0, 2'b00, 32'h0000_0007, 32'h0,        1'b0, 32'h00000080, 3};
        vecs[3]  = '{1'b1, 1'b0, 2'b11, 32'h0000_0020, 32'h0,        1'b0, 32'h0000CCDD, 9};
        vecs[4]  = '{1'b1, 1'b1, 2'b10, 32'h0000_0040, 32'h12345678, 1'b0, 32'h0,        5};
        vecs[5]  = '{1'b1, 1'b0, 2'b10, 32'h0000_0040, 32'h0,        1'b1, 32'h12345678, 9};
        vecs[6]  = '{1'b1, 1'b0, 2'b00, 32'h0000_0041, 32'h0,        1'b0, 32'h00000056, 3};
        vecs[7]  = '{1'b1, 1'b0, 2'b01, 32'h0000_0042, 32'h0,        1'b0, 32'h00001234, 5};
        vecs[8]  = '{1'b1, 1'b1, 2'b00, 32'h0000_0043, 32'hFFFFFF9A, 1'b0, 32'h0,        2};
        vecs[9]  = '{1'b0, 1'b0, 2'b00, 32'h0000_0040, 32'h0,        1'b0, 32'h9A345678, 9};
        vecs[10] = '{1'b1, 1'b1, 2'b01, 32'hFFFF_FFFF, 32'h0000A1B2, 1'b0, 32'h0,        3};
        vecs[11] = '{1'b1, 1'b0, 2'b01, 32'hFFFF_FFFF, 32'h0,        1'b0, 32'h0000A1B2, 5};
        vecs[12] = '{1'b1, 1'b0, 2'b00, 32'h0000_0000, 32'h0,        1'b0, 32'h000000A1, 3};
        vecs[13] = '{1'b1, 1'b1, 2'b10, 32'h0000_0060, 32'hDEADBEEF, 1'b1, 32'h0,        5};
        vecs[14] = '{1'b0, 1'b0, 2'b00, 32'h0000_0060, 32'h0,        1'b0, 32'hDEADBEEF, 9};

        // Reset state and RAM preload
        ram_clr = 1'b1;
        step();
        ram_clr = 1'b0;
        poke(10'h100, 8'h11);
        poke(10'h101, 8'h22);
        poke(10'h102, 8'h33);
        poke(10'h103, 8'h44);
        poke(10'h007, 8'h80);
        check_reset_outputs("reset");
        check("reset_dut1", {b1.ram_addr, b1.ram_wr, b1.if_done, b1.mem_done, b1.busy}, 0);
        @(negedge clk);
        rst = 1'b1;
        step();

        // Directed vector table
        for (int i = 0; i < 15; i++) begin
            run_txn(vecs[i].mem, vecs[i].we, vecs[i].size, vecs[i].addr, vecs[i].wdata,
                    vecs[i].flush, rd, lat);
            check($sformatf("vec%0d_lat", i), lat, vecs[i].exp_lat);
            if (vecs[i].mem && vecs[i].we)
                model_write(vecs[i].addr, vecs[i].wdata, nbytes(vecs[i].mem, vecs[i].size));
            else
                check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
        end
        check("ram_0x22_untouched", ram[10'h022], 8'h00);

        // Simultaneous requests, fixed priority: MEM first, IF right after
        b0.mem_addr_i = 32'h7; b0.mem_size = 2'b00; b0.mem_we = 1'b0; b0.if_addr = 32'h100;
        b0.mem_req = 1'b1; b0.if_req = 1'b1;
        mem_at = 0; if_at = 0; rd = '0;
        for (int c = 1; c <= 60 && if_at == 0; c++) begin
            step();
            if (b0.mem_done && mem_at == 0) begin mem_at = c; b0.mem_req = 1'b0; end
            if (b0.if_done && if_at == 0) begin if_at = c; rd = b0.rdata_o; b0.if_req = 1'b0; end
        end
        b0.mem_req = 1'b0; b0.if_req = 1'b0;
        step();
        check("arb0_mem_lat", mem_at, 3);
        check("arb0_if_lat", if_at, 13);
        check("arb0_if_rdata", rd, 32'h44332211);

        // Flush during beat 2 of an IF read, with a MEM request pending
        ifd = 0;
        b0.if_addr = 32'h100; b0.if_req = 1'b1;
        for (int c = 0; c < 5; c++) begin
            step();
            if (b0.if_done) ifd++;
        end
        b0.if_flush = 1'b1;
        b0.mem_req = 1'b1; b0.mem_we = 1'b0; b0.mem_size = 2'b00; b0.mem_addr_i = 32'h7;
        step();
        if (b0.if_done) ifd++;
        check("flush_idle", b0.busy, 0);
        check("flush_rdata_kept", b0.rdata_o, 32'h00002211);
        check("flush_no_wr", b0.ram_wr, 0);
        b0.if_req = 1'b0; b0.if_flush = 1'b0;
        step();
        check("flush_then_mem_grant", b0.busy, 1);
        mem_at = 0; rd = '0;
        for (int c = 1; c <= 20 && mem_at == 0; c++) begin
            step();
            if (b0.if_done) ifd++;
            if (b0.mem_done) begin mem_at = c; rd = b0.rdata_o; end
        end
        b0.mem_req = 1'b0;
        step();
        check("flush_mem_lat", mem_at, 2);
        check("flush_mem_rdata", rd, 32'h00000080);
        check("flush_no_if_done", ifd, 0);

        // Reset asserted during beat 1 of a word write
        b0.mem_addr_i = 32'h80; b0.mem_we = 1'b1; b0.mem_size = 2'b10;
        b0.mem_wdata = 32'h5566778A; b0.mem_req = 1'b1;
        step();
        step();
        rst = 1'b0;
        #1;
        check_reset_outputs("rst_mid");
        b0.mem_req = 1'b0; b0.mem_we = 1'b0;
        model_mem[10'h080] = 8'h8A;
        @(negedge clk);
        rst = 1'b1;
        step();
        check("partial_write_byte0", ram[10'h080], 8'h8A);
        check("partial_write_byte1", ram[10'h081], 8'h00);
        run_txn(1'b1, 1'b0, 2'b10, 32'h80, 32'h0, 1'b0, rd, lat);
        check("post_rst_lat", lat, 9);
        check("post_rst_rdata", rd, 32'h0000008A);

        // Randomized traffic against the reference model
        for (int t = 0; t < 40; t++) begin
            r_mem   = 1'($urandom_range(0, 1));
            r_we    = r_mem && (1'($urandom_range(0, 1)) == 1'b1);
            r_flush = r_mem && (1'($urandom_range(0, 1)) == 1'b1);
            r_size  = 2'($urandom_range(0, 3));
            r_addr  = $urandom;
            r_wdata = $urandom;
            exp_rd  = model_read(r_addr, nbytes(r_mem, r_size));
            run_txn(r_mem, r_we, r_size, r_addr, r_wdata, r_flush, rd, lat);
            check("rand_lat", lat, model_lat(r_mem, r_we, r_size));
            if (r_we) model_write(r_addr, r_wdata, nbytes(r_mem, r_size));
            else      check("rand_rdata", rd, exp_rd);
            repeat ($urandom_range(0, 2)) step();
        end
        mism = 0;
        for (int i = 0; i < 1024; i++) if (ram[i] !== model_mem[i]) mism++;
        check("ram_image", mism, 0);

        // Round-robin instance with both channels requesting continuously
        b1.mem_addr_i = 32'h10; b1.mem_size = 2'b00; b1.mem_we = 1'b0; b1.if_addr = 32'h20;
        b1.mem_req = 1'b1; b1.if_req = 1'b1;
        mem_rearm = 1'b0; if_rearm = 1'b0;
        for (int c = 0; c < 400 && order.size() < 4; c++) begin
            step();
            if (mem_rearm) begin b1.mem_req = 1'b1; mem_rearm = 1'b0; end
            if (if_rearm)  begin b1.if_req  = 1'b1; if_rearm  = 1'b0; end
            if (b1.mem_done) begin order.push_back(1); b1.mem_req = 1'b0; mem_rearm = 1'b1; end
            if (b1.if_done)  begin order.push_back(0); b1.if_req  = 1'b0; if_rearm  = 1'b1; end
        end
        b1.mem_req = 1'b0; b1.if_req = 1'b0;
        step();
        step();
        for (int i = 0; i < 4; i++) begin
            check($sformatf("rr_grant%0d_is_mem", i),
                  (i < order.size()) ? order[i] : 2, (i % 2 == 0) ? 1 : 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
